topk_senone_tracker: RTL and testbench
======================================

Name: topk_senone_tracker

Overview:
- Generalised successor to the single-best score tracker in the senone scoring path.
- Per feature vector (frame), it keeps the K highest senone scores together with their senone IDs, sorted in descending order, and derives a saturating beam-pruning threshold from the best score.
- Sits between the senone scorer and the HMM/Viterbi stage, which reads the sorted list once `max_done` is raised.

Parameters:
- SCORE_W, 16, width of signed score (matches package type `num`).
- ID_W, 13, width of senone ID.
- K, 4, number of best entries retained (1..16).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- new_vector_available  in  1  frame start; clears list and done.
- new_senone  in  1  current_score/current_id valid this cycle.
- last_senone  in  1  qualifies new_senone; marks final senone of frame.
- current_score  in  SCORE_W  signed score.
- current_id  in  ID_W  senone ID.
- beam  in  SCORE_W  unsigned beam width; sampled continuously.
- done_ack  in  1  consumer has read results.
- best_score  out  K*SCORE_W  slot 0 = highest; packed, slot i at bits [i*SCORE_W +: SCORE_W].
- best_id  out  K*ID_W  IDs matching best_score slots.
- best_valid  out  K  slot occupied.
- prune_thresh  out  SCORE_W  best_score[0] - beam, saturated at SCORE_MIN.
- max_done  out  1  results final and stable.

Behaviour:
- Reset (async) and the clear action set:
  - every best_score slot to SCORE_MIN (16'h8000);
  - best_id to 0, best_valid to 0;
  - prune_thresh to SCORE_MIN;
  - max_done to 0;
  - state to ACCUM.
- States:
  - ACCUM: accepts senones.
  - DONE: max_done=1; ignores new_senone; outputs frozen.
- Transitions:
  - ACCUM -> DONE on an accepted new_senone with last_senone=1. max_done rises the cycle after acceptance, with the final entry already inserted.
  - DONE -> ACCUM on done_ack. Outputs are held; max_done falls the next cycle.
  - Any state -> ACCUM with cleared list on new_vector_available.
- Insertion (single cycle, registered, latency 1): a new entry is placed at the first slot i where either
  - best_valid[i]=0, or
  - current_score > best_score[i] (signed compare).
- Shift rule:
  - Slots i..K-2 shift down one position; slot K-1 is discarded.
  - If no slot qualifies, the list is unchanged.
- Ties: an equal score inserts after existing equal entries, so the earlier-arriving ID ranks higher.
- An empty slot accepts any score, including SCORE_MIN; occupancy is tracked by best_valid, never by the sentinel value.
- prune_thresh:
  - Registered from the next-state value of slot 0, so it is updated in the same cycle as the list.
  - Computed in SCORE_W+1 bits; a result below SCORE_MIN clamps to SCORE_MIN.
  - Equals SCORE_MIN while best_valid[0]=0.
- Simultaneous new_vector_available and new_senone: clear takes priority and the presented senone is loaded as slot 0 of the new frame. If last_senone is also set, max_done rises the next cycle.
- new_senone in DONE state: dropped, with no change to any output.
- last_senone without new_senone: ignored.
- done_ack in ACCUM: ignored.
- Reset mid-frame: all outputs return to reset values asynchronously; no partial results persist.

Decomposition:
- Shared package p3p_pkg contains:
  - typedef num (logic signed [15:0]);
  - constant SCORE_MIN = 16'sh8000;
  - typedef senone_id_t (logic [12:0]).
- One sub-module, topk_slot: holds one score/ID/valid register and computes its "take new" versus "take upper neighbour" select from the compare of the incoming score with its own and the upper slot's result. The module is generated K times.

Test Plan:
- K=4, scores 10,50,-3,50,7 with IDs 1..5, last on ID 5 → scores 50,50,10,7; ids 2,4,1,5; valid 1111; max_done=1 one cycle later.
- Two senones only (−100 id 9, SCORE_MIN id 3, last) → valid 0011; slot1 score 16'h8000 id 3; slots 2,3 remain SCORE_MIN/0.
- beam=100, best=-32700 → prune_thresh=-32768 (saturated); then best=200 → prune_thresh=100.
- In DONE, present new_senone score 1000 → list unchanged; done_ack → max_done=0 next cycle; next senone accepted.
- new_vector_available with new_senone (score 5, id 7) in the same cycle mid-frame → list becomes {5/7, empty×3}, max_done=0.
- Assert reset between senone 2 and senone 3 of a frame → all outputs at reset values immediately; subsequent frame results are unaffected by pre-reset data.

Source files
------------

// File: rtl/p3p_pkg.sv
// p3p_pkg: score/ID types and tracker state shared across the senone scoring path.
package p3p_pkg;
   typedef logic signed [15:0] num;
   typedef logic [12:0] senone_id_t;
   localparam num SCORE_MIN = 16'sh8000;
   typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} state_t;
endpackage

// File: rtl/topk_slot.sv
// topk_slot: one ranked score/ID/valid entry; takes the new entry, its upper
// neighbour, or holds, based on where the insertion point falls.
module topk_slot #(
   parameter int SCORE_W = 16,
   parameter int ID_W    = 13
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_clr,
   input  logic                      i_acc,
   input  logic signed [SCORE_W-1:0] i_score,
   input  logic [ID_W-1:0]           i_id,
   input  logic                      i_up_q,
   input  logic signed [SCORE_W-1:0] i_up_score,
   input  logic [ID_W-1:0]           i_up_id,
   input  logic                      i_up_valid,
   output logic                      o_q,
   output logic signed [SCORE_W-1:0] o_eff_score,
   output logic [ID_W-1:0]           o_eff_id,
   output logic                      o_eff_valid,
   output logic signed [SCORE_W-1:0] o_nxt_score,
   output logic [ID_W-1:0]           o_nxt_id,
   output logic                      o_nxt_valid,
   output logic signed [SCORE_W-1:0] o_score,
   output logic [ID_W-1:0]           o_id,
   output logic                      o_valid
);
   localparam logic signed [SCORE_W-1:0] MIN = {1'b1, {(SCORE_W-1){1'b0}}};

   logic signed [SCORE_W-1:0] r_score;
   logic [ID_W-1:0]           r_id;
   logic                      r_valid;
   logic                      w_q;

   // Strict compare keeps equal scores behind earlier arrivals.
   always_comb begin
      o_eff_valid = r_valid & ~i_clr;
      o_eff_score = i_clr ? MIN : r_score;
      o_eff_id    = i_clr ? '0 : r_id;
      w_q         = ~o_eff_valid | (i_score > o_eff_score);
      o_q         = i_up_q | w_q;
      o_nxt_valid = !i_acc ? o_eff_valid : i_up_q ? i_up_valid : (w_q | o_eff_valid);
      o_nxt_score = !i_acc ? o_eff_score : i_up_q ? i_up_score : w_q ? i_score : o_eff_score;
      o_nxt_id    = !i_acc ? o_eff_id    : i_up_q ? i_up_id    : w_q ? i_id    : o_eff_id;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_score <= MIN;
         r_id    <= '0;
         r_valid <= 1'b0;
      end else begin
         r_score <= o_nxt_score;
         r_id    <= o_nxt_id;
         r_valid <= o_nxt_valid;
      end

   assign o_score = r_score;
   assign o_id    = r_id;
   assign o_valid = r_valid;
endmodule

// File: rtl/topk_senone_tracker.sv
// topk_senone_tracker: keeps the K best senone scores/IDs of a frame in
// descending order and derives a saturated beam-pruning threshold.
module topk_senone_tracker
   import p3p_pkg::*;
#(
   parameter int SCORE_W = 16,
   parameter int ID_W    = 13,
   parameter int K       = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   new_vector_available,
   input  logic                   new_senone,
   input  logic                   last_senone,
   input  logic [SCORE_W-1:0]     current_score,
   input  logic [ID_W-1:0]        current_id,
   input  logic [SCORE_W-1:0]     beam,
   input  logic                   done_ack,
   output logic [K*SCORE_W-1:0]   best_score,
   output logic [K*ID_W-1:0]      best_id,
   output logic [K-1:0]           best_valid,
   output logic [SCORE_W-1:0]     prune_thresh,
   output logic                   max_done
);
   localparam logic signed [SCORE_W-1:0] MIN = {1'b1, {(SCORE_W-1){1'b0}}};

   state_t                    r_state, w_state_nxt;
   logic [SCORE_W-1:0]        r_prune;
   logic                      w_acc;
   logic                      w_q       [K];
   logic signed [SCORE_W-1:0] w_eff_s   [K];
   logic [ID_W-1:0]           w_eff_id  [K];
   logic                      w_eff_v   [K];
   logic signed [SCORE_W-1:0] w_nxt_s   [K];
   logic [ID_W-1:0]           w_nxt_id  [K];
   logic                      w_nxt_v   [K];
   logic signed [SCORE_W:0]   w_diff;
   logic [SCORE_W-1:0]        w_prune_nxt;

   assign w_acc = new_senone & (new_vector_available | (r_state == ACCUM));

   genvar g;
   generate
      for (g = 0; g < K; g++) begin : g_slot
         logic                      w_up_q;
         logic signed [SCORE_W-1:0] w_up_s;
         logic [ID_W-1:0]           w_up_id;
         logic                      w_up_v;
         logic signed [SCORE_W-1:0] w_s;
         logic [ID_W-1:0]           w_id;
         if (g == 0) begin : g_top
            assign w_up_q  = 1'b0;
            assign w_up_s  = MIN;
            assign w_up_id = '0;
            assign w_up_v  = 1'b0;
         end else begin : g_rest
            assign w_up_q  = w_q[g-1];
            assign w_up_s  = w_eff_s[g-1];
            assign w_up_id = w_eff_id[g-1];
            assign w_up_v  = w_eff_v[g-1];
         end
         topk_slot #(.SCORE_W(SCORE_W), .ID_W(ID_W)) u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_clr       (new_vector_available),
            .i_acc       (w_acc),
            .i_score     (current_score),
            .i_id        (current_id),
            .i_up_q      (w_up_q),
            .i_up_score  (w_up_s),
            .i_up_id     (w_up_id),
            .i_up_valid  (w_up_v),
            .o_q         (w_q[g]),
            .o_eff_score (w_eff_s[g]),
            .o_eff_id    (w_eff_id[g]),
            .o_eff_valid (w_eff_v[g]),
            .o_nxt_score (w_nxt_s[g]),
            .o_nxt_id    (w_nxt_id[g]),
            .o_nxt_valid (w_nxt_v[g]),
            .o_score     (w_s),
            .o_id        (w_id),
            .o_valid     (best_valid[g])
         );
         assign best_score[g*SCORE_W +: SCORE_W] = w_s;
         assign best_id[g*ID_W +: ID_W]          = w_id;
      end
   endgenerate

   // One extra bit exposes underflow: top two bits differ only when below MIN.
   always_comb begin
      w_diff      = {w_nxt_s[0][SCORE_W-1], w_nxt_s[0]} - {1'b0, beam};
      w_prune_nxt = (!w_nxt_v[0] || (w_diff[SCORE_W] ^ w_diff[SCORE_W-1])) ? MIN : w_diff[SCORE_W-1:0];
   end

   always_comb begin
      w_state_nxt = r_state;
      if (new_vector_available)
         w_state_nxt = (new_senone && last_senone) ? DONE : ACCUM;
      else if (r_state == ACCUM && new_senone && last_senone)
         w_state_nxt = DONE;
      else if (r_state == DONE && done_ack)
         w_state_nxt = ACCUM;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         r_state <= ACCUM;
         r_prune <= MIN;
      end else begin
         r_state <= w_state_nxt;
         r_prune <= w_prune_nxt;
      end

   assign prune_thresh = r_prune;
   assign max_done     = (r_state == DONE);
endmodule

// File: tb/tb_topk_senone_tracker.sv
// tb_topk_senone_tracker: directed-vector bench for the K=4 senone tracker.
module tb_topk_senone_tracker;
   logic        clk, reset, nva, ns, last, ack;
   logic [15:0] score, beam, prune;
   logic [12:0] id;
   logic [63:0] bs;
   logic [51:0] bi;
   logic [3:0]  bv;
   logic        done;
   int checks = 0, errors = 0;

   topk_senone_tracker #(.SCORE_W(16), .ID_W(13), .K(4)) dut (
      .clk(clk), .reset(reset), .new_vector_available(nva), .new_senone(ns),
      .last_senone(last), .current_score(score), .current_id(id), .beam(beam),
      .done_ack(ack), .best_score(bs), .best_id(bi), .best_valid(bv),
      .prune_thresh(prune), .max_done(done)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic v, input logic n, input logic l, input logic [15:0] s,
                       input logic [12:0] i, input logic a);
      nva = v; ns = n; last = l; score = s; id = i; ack = a;
      @(posedge clk);
      #1;
      nva = 0; ns = 0; last = 0; ack = 0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_score"}, bs, 64'h8000_8000_8000_8000);
      chk({tag, "_id"}, {12'd0, bi}, 64'd0);
      chk({tag, "_valid"}, {60'd0, bv}, 64'd0);
      chk({tag, "_prune"}, {48'd0, prune}, 64'h8000);
      chk({tag, "_done"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      reset = 1; nva = 0; ns = 0; last = 0; ack = 0; score = 0; id = 0; beam = 16'd100;
      #12;
      chk_reset("reset");
      reset = 0;

      // frame 1: ties and a full list
      step(1, 0, 0, 0, 0, 0);
      chk_reset("clear");
      step(0, 1, 0, 16'd10, 13'd1, 0);
      step(0, 1, 0, 16'd50, 13'd2, 0);
      step(0, 1, 0, -16'sd3, 13'd3, 0);
      step(0, 1, 0, 16'd50, 13'd4, 0);
      chk("f1_pre_done", {63'd0, done}, 64'd0);
      step(0, 1, 1, 16'd7, 13'd5, 0);
      chk("f1_score", bs, 64'h0007_000A_0032_0032);
      chk("f1_id", {12'd0, bi}, {12'd0, 13'd5, 13'd1, 13'd4, 13'd2});
      chk("f1_valid", {60'd0, bv}, 64'hF);
      chk("f1_done", {63'd0, done}, 64'd1);
      chk("f1_prune", {48'd0, prune}, 64'hFFCE);

      // DONE drops senones, ack releases
      step(0, 1, 0, 16'd1000, 13'd9, 0);
      chk("dn_score", bs, 64'h0007_000A_0032_0032);
      chk("dn_done", {63'd0, done}, 64'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("ack_done", {63'd0, done}, 64'd0);
      chk("ack_hold", bs, 64'h0007_000A_0032_0032);
      step(0, 1, 0, 16'd60, 13'd6, 0);
      chk("post_ack_score", bs, 64'h000A_0032_0032_003C);
      chk("post_ack_id", {12'd0, bi}, {12'd0, 13'd1, 13'd4, 13'd2, 13'd6});
      chk("post_ack_prune", {48'd0, prune}, 64'hFFD8);

      // clear and load in the same cycle
      step(1, 1, 0, 16'd5, 13'd7, 0);
      chk("nva_ns_score", bs, 64'h8000_8000_8000_0005);
      chk("nva_ns_id", {12'd0, bi}, 64'd7);
      chk("nva_ns_valid", {60'd0, bv}, 64'h1);
      chk("nva_ns_done", {63'd0, done}, 64'd0);
      chk("nva_ns_prune", {48'd0, prune}, 64'hFFA1);

      // SCORE_MIN occupies an empty slot
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, -16'sd100, 13'd9, 0);
      step(0, 1, 1, 16'h8000, 13'd3, 0);
      chk("min_score", bs, 64'h8000_8000_8000_FF9C);
      chk("min_id", {12'd0, bi}, {12'd0, 13'd0, 13'd0, 13'd3, 13'd9});
      chk("min_valid", {60'd0, bv}, 64'h3);
      chk("min_done", {63'd0, done}, 64'd1);
      chk("min_prune", {48'd0, prune}, 64'hFF38);

      // prune saturation from DONE via clear+load
      step(1, 1, 0, 16'h8044, 13'd1, 0);
      chk("sat_prune", {48'd0, prune}, 64'h8000);
      chk("sat_done", {63'd0, done}, 64'd0);
      step(0, 1, 0, 16'd200, 13'd2, 0);
      chk("sat_prune2", {48'd0, prune}, 64'h0064);
      chk("sat_score", bs, 64'h8000_8000_8044_00C8);

      // clear+load+last finishes a one-senone frame
      step(1, 1, 1, 16'd3, 13'd4, 0);
      chk("one_done", {63'd0, done}, 64'd1);
      chk("one_valid", {60'd0, bv}, 64'h1);

      // async reset mid-frame
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 16'd30, 13'd1, 0);
      step(0, 1, 0, 16'd40, 13'd2, 0);
      #2 reset = 1;
      #1;
      chk_reset("async_rst");
      reset = 0;
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, -16'sd5, 13'd7, 0);
      chk("pr_score", bs, 64'h8000_8000_8000_FFFB);
      chk("pr_id", {12'd0, bi}, 64'd7);
      chk("pr_valid", {60'd0, bv}, 64'h1);
      chk("pr_done", {63'd0, done}, 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
